// File: rtl/mrtu_rx_framer.sv
// Modbus RTU receive framer: splits the UART byte stream into frames on line silence and checks each CRC-16.
// Latency: the result (frame_done/ok/len) appears GAP_TICKS bit times after the last byte, plus 2 clk.
// Backpressure: none. Bytes must arrive at least 2 clk apart, which any UART rate guarantees.

// CRC-16/MODBUS engine. Reflected polynomial 0xA001, preset 0xFFFF. Bytes are folded in LSB first.
module mrtu_mcrc (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clr,
   input  logic        i_ready,
   input  logic [7:0]  i_din,
   output logic [15:0] o_crc
);
   logic [15:0] r_crc;
   logic [15:0] w_crc_nxt;

   // Fold one byte into the running remainder, one bit per iteration
   always_comb begin
      w_crc_nxt = r_crc ^ {8'h00, i_din};
      for (int i = 0; i < 8; i++) begin
         w_crc_nxt = w_crc_nxt[0] ? ((w_crc_nxt >> 1) ^ 16'hA001) : (w_crc_nxt >> 1);
      end
   end

   // Remainder register: clear has priority over a byte strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_crc <= 16'hFFFF;
      end else if (i_clr) begin
         r_crc <= 16'hFFFF;
      end else if (i_ready) begin
         r_crc <= w_crc_nxt;
      end
   end

   assign o_crc = r_crc;
endmodule

module mrtu_rx_framer #(
   parameter int GAP_TICKS = 38,
   parameter int MAXLEN    = 256,
   parameter int LW        = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          rx_err,
   output logic          frame_done,
   output logic          frame_ok,
   output logic [LW-1:0] frame_len,
   output logic          busy,
   output logic [15:0]   crc
);
   localparam int GW = $clog2(GAP_TICKS + 1);

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_IDLE,
      ST_RECV,
      ST_DISCARD,
      ST_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [GW-1:0] r_gap;
   logic [LW-1:0] r_len;
   logic [LW-1:0] w_len_nxt;
   logic          r_bad;
   logic          w_bad_nxt;
   logic          r_hold_vld;
   logic [7:0]    r_hold_dat;
   logic          w_hold_ld;
   logic          r_frame_ok;
   logic [LW-1:0] r_frame_len;
   logic          w_cap;
   logic          w_crc_clr;
   logic          w_crc_rdy;
   logic [7:0]    w_crc_din;
   logic          w_rx_any;
   logic          w_gap;
   logic          w_len_full;
   logic [15:0]   w_crc;

   assign w_rx_any   = rx_valid | rx_err;
   // A byte or error on the same cycle always beats the silence timeout.
   assign w_gap      = (r_gap == GW'(GAP_TICKS)) && !w_rx_any;
   assign w_len_full = (r_len >= LW'(MAXLEN));

   // Silence timer: counts bit times since the last line activity, saturating at the gap length
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gap <= '0;
      end else if (w_rx_any) begin
         r_gap <= '0;
      end else if (tick && (r_gap != GW'(GAP_TICKS))) begin
         r_gap <= r_gap + GW'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, byte routing to the CRC engine, and frame length/bad tracking
   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_bad_nxt   = r_bad;
      w_crc_clr   = 1'b0;
      w_crc_rdy   = 1'b0;
      w_crc_din   = rx_data;
      w_hold_ld   = 1'b0;
      w_cap       = 1'b0;

      // A byte caught during DONE goes to the engine one clk late, after its clear.
      if (r_hold_vld) begin
         w_crc_rdy = 1'b1;
         w_crc_din = r_hold_dat;
      end

      case (r_state)
         ST_SYNC: begin
            w_crc_clr = 1'b1;
            if (w_gap) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (rx_valid) begin
               w_state_nxt = ST_RECV;
               w_crc_rdy   = 1'b1;
               w_crc_din   = rx_data;
               w_len_nxt   = LW'(1);
            end else if (rx_err) begin
               w_state_nxt = ST_DISCARD;
               w_len_nxt   = '0;
               w_bad_nxt   = 1'b1;
            end
         end
         ST_RECV: begin
            if (rx_valid) begin
               if (!w_len_full) begin
                  w_crc_rdy = 1'b1;
                  w_crc_din = rx_data;
                  w_len_nxt = r_len + LW'(1);
               end else begin
                  w_bad_nxt   = 1'b1;
                  w_state_nxt = ST_DISCARD;
               end
            end else if (rx_err) begin
               w_bad_nxt   = 1'b1;
               w_state_nxt = ST_DISCARD;
            end else if (w_gap) begin
               w_cap       = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DISCARD: begin
            if (rx_valid && !w_len_full) begin
               w_len_nxt = r_len + LW'(1);
            end
            if (w_gap) begin
               w_cap       = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_crc_clr = 1'b1;
            w_len_nxt = '0;
            w_bad_nxt = 1'b0;
            if (rx_valid) begin
               w_state_nxt = ST_RECV;
               w_len_nxt   = LW'(1);
               w_hold_ld   = 1'b1;
            end else if (rx_err) begin
               w_state_nxt = ST_DISCARD;
               w_bad_nxt   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_SYNC;
         end
      endcase
   end

   // Frame bookkeeping and the one-clk hold of a byte that arrives during DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_len      <= '0;
         r_bad      <= 1'b0;
         r_hold_vld <= 1'b0;
         r_hold_dat <= '0;
      end else begin
         r_len      <= w_len_nxt;
         r_bad      <= w_bad_nxt;
         r_hold_vld <= w_hold_ld;
         if (w_hold_ld) begin
            r_hold_dat <= rx_data;
         end
      end
   end

   // Latch the verdict on entry to DONE so it is valid with frame_done and holds until the next frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame_ok  <= 1'b0;
         r_frame_len <= '0;
      end else if (w_cap) begin
         r_frame_ok  <= (r_len >= LW'(4)) && (w_crc == 16'h0000) && !r_bad;
         r_frame_len <= r_len;
      end
   end

   mrtu_mcrc u_mcrc (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_crc_clr),
      .i_ready (w_crc_rdy),
      .i_din   (w_crc_din),
      .o_crc   (w_crc)
   );

   assign frame_done = (r_state == ST_DONE);
   assign frame_ok   = r_frame_ok;
   assign frame_len  = r_frame_len;
   assign busy       = (r_state == ST_RECV) || (r_state == ST_DISCARD);
   assign crc        = w_crc;
endmodule

// File: tb/tb_mrtu_rx_framer.sv
// Randomized scoreboard bench for mrtu_rx_framer.
// A frame-level model (byte lists, a silence counter and a CRC accumulator) pushes the expected verdicts.
// A monitor pops and compares those verdicts on every frame_done.
module tb_mrtu_rx_framer;
   localparam int GAP  = 38;
   localparam int MAXL = 8;
   localparam int LW   = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tick = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_err = 1'b0;
   logic          frame_done;
   logic          frame_ok;
   logic [LW-1:0] frame_len;
   logic          busy;
   logic [15:0]   crc;

   mrtu_rx_framer #(.GAP_TICKS(GAP), .MAXLEN(MAXL), .LW(LW)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_err     (rx_err),
      .frame_done (frame_done),
      .frame_ok   (frame_ok),
      .frame_len  (frame_len),
      .busy       (busy),
      .crc        (crc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic [31:0] len;
   } exp_t;

   exp_t       exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] frm[$];

   // Frame-level reference model state
   bit          m_sync;
   int          m_gap;
   bit          m_active;
   bit          m_bad;
   int          m_n;
   logic [15:0] m_crc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] x;
      x = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         if (x[0]) x = (x >> 1) ^ 16'hA001;
         else      x = x >> 1;
      end
      return x;
   endfunction

   task automatic model_close();
      exp_t e;
      int   len;
      len   = (m_n > MAXL) ? MAXL : m_n;
      e.ok  = !m_bad && (m_n <= MAXL) && (m_n >= 4) && (m_crc == 16'h0000);
      e.len = len;
      exp_q.push_back(e);
      m_active = 0;
   endtask

   // One clock of stimulus. The model sees the same event the DUT samples at the next posedge.
   task automatic cyc(input logic t, input logic v, input logic [7:0] d, input logic e);
      tick = t; rx_valid = v; rx_data = d; rx_err = e;
      if (reset) begin
         if (v || e) begin
            m_gap = 0;
            if (m_sync) begin
               if (!m_active) begin
                  m_active = 1; m_bad = 0; m_n = 0; m_crc = 16'hFFFF;
               end
               if (v) begin
                  m_n++;
                  m_crc = crc_step(m_crc, d);
               end else begin
                  m_bad = 1;
               end
            end
         end else if (t && m_gap < GAP) begin
            m_gap++;
            if (m_gap == GAP) begin
               if (!m_sync) m_sync = 1;
               else if (m_active) model_close();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // n bit times of silence, two clocks per bit time
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 8'h00, 1'b0);
         cyc(1'b0, 1'b0, 8'h00, 1'b0);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      cyc(1'b0, 1'b1, b, 1'b0);
      idle(10);
   endtask

   task automatic send_err();
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      idle(10);
   endtask

   // Sends frm[from..]; an error strobe is inserted before index err_at (use -1 for none)
   task automatic send_frm(input int from, input int err_at);
      for (int i = from; i < frm.size(); i++) begin
         if (i == err_at) send_err();
         send_byte(frm[i]);
      end
   endtask

   task automatic build_good(input int n);
      logic [15:0] c;
      frm.delete();
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         frm.push_back(8'($urandom_range(0, 255)));
         c = crc_step(c, frm[i]);
      end
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_sync = 0; m_gap = 0; m_active = 0;
      repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
      reset = 1'b1;
   endtask

   // Idle until frame_done is seen, then send b on that very cycle (bounded wait)
   task automatic idle_then_byte_on_done(input logic [7:0] b);
      bit seen;
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         if (frame_done) begin
            seen = 1;
            send_byte(b);
         end else begin
            cyc(k % 2 == 0, 1'b0, 8'h00, 1'b0);
         end
      end
      if (!seen) chk("done_wait_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (reset === 1'b1 && frame_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("frame_ok", {31'd0, frame_ok}, {31'd0, e.ok});
            chk("frame_len", {28'd0, frame_len}, e.len);
         end
      end
   end

   initial begin
      m_sync = 0; m_gap = 0; m_active = 0; m_bad = 0; m_n = 0; m_crc = 16'hFFFF;
      do_reset();
      reset = 1'b0;
      #1;
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
      chk("rst_frame_len", {28'd0, frame_len}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_crc", {16'd0, crc}, 32'h0000FFFF);
      reset = 1'b1;

      // Known-good frame; also check the live CRC after the payload
      idle(40);
      frm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frm(0, -1);
      chk("crc_after_payload", {16'd0, crc}, {16'd0, m_crc});
      frm = '{8'h9B, 8'hC1};
      send_frm(0, -1);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      idle(40);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);

      // Corrupted last byte
      frm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h9B, 8'hC0};
      send_frm(0, -1);
      idle(40);

      // Short frame with a zero residue
      frm = '{8'hFF, 8'hFF};
      send_frm(0, -1);
      idle(40);

      // Overflow past MAXLEN, then a good frame of exactly MAXLEN
      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(8'($urandom_range(0, 255)));
      send_frm(0, -1);
      chk("busy_overflow", {31'd0, busy}, 32'd1);
      idle(40);
      build_good(MAXL - 2);
      send_frm(0, -1);
      idle(40);

      // Bytes before the initial silence are dropped
      do_reset();
      idle(20);
      frm = '{8'hAA, 8'h55};
      send_frm(0, -1);
      idle(40);
      build_good(4);
      send_frm(0, -1);
      idle(40);

      // Error mid-frame, then a clean frame
      build_good(4);
      send_frm(0, 2);
      idle(40);
      frm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h9B, 8'hC1};
      send_frm(0, -1);
      idle(40);

      // A lone error strobe forms a bad empty frame
      send_err();
      idle(40);

      // Back-to-back: first byte of the next frame lands on the DONE cycle
      build_good(3);
      send_frm(0, -1);
      build_good(4);
      idle_then_byte_on_done(frm[0]);
      send_frm(1, -1);
      idle(40);

      // Reset mid-frame abandons the frame
      build_good(4);
      for (int i = 0; i < 3; i++) send_byte(frm[i]);
      do_reset();
      chk("busy_after_midreset", {31'd0, busy}, 32'd0);
      chk("crc_after_midreset", {16'd0, crc}, 32'h0000FFFF);
      idle(40);
      build_good(5);
      send_frm(0, -1);
      idle(40);

      // Randomized frames: good, corrupted, or with an error strobe
      for (int f = 0; f < 20; f++) begin
         int mode;
         mode = $urandom_range(0, 2);
         build_good($urandom_range(0, 7));
         if (mode == 1) begin
            int p;
            p = $urandom_range(0, frm.size() - 1);
            frm[p] = frm[p] ^ 8'($urandom_range(1, 255));
         end
         send_frm(0, (mode == 2) ? int'($urandom_range(0, frm.size() - 1)) : -1);
         idle(40 + $urandom_range(0, 5));
      end

      idle(5);
      chk("pending_frames", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
